// File: rtl/sobel_edge_filter.sv
// Streaming Sobel edge detector: RGB -> luma, 3x3 window over two line buffers,
// |Gx|+|Gy| against a live threshold, valid/ready on both sides with a global stall.
module sobel_edge_filter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  threshold,
  input  logic [23:0] data_m_rgb,
  input  logic        valid_m,
  output logic        ready_s,
  output logic        valid_s,
  input  logic        ready_m,
  output logic [23:0] data_s_sobel
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic w_en;
  assign w_en    = !valid_s || ready_m;
  assign ready_s = w_en && !rst;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Input capture register ahead of the luma stage; gives 4 edges from acceptance to valid_s.
  logic          r_s0_valid, r_s0_border;
  logic [23:0]   r_s0_rgb;
  logic [CW-1:0] r_s0_col;

  logic          r_s1_valid, r_s1_border;
  logic [7:0]    r_s1_y;
  logic [CW-1:0] r_s1_col;

  logic          r_s2_valid, r_s2_border;
  logic [7:0]    r_p00, r_p01, r_p02, r_p10, r_p11, r_p12, r_p20, r_p21, r_p22;

  logic               r_s3_valid, r_s3_border;
  logic signed [10:0] r_gx, r_gy;

  logic [7:0] r_lb0 [IMG_WIDTH];
  logic [7:0] r_lb1 [IMG_WIDTH];

  logic [15:0] w_luma_sum;
  logic [7:0]  w_lb0, w_lb1;
  logic [10:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [10:0] w_ax, w_ay;
  logic [11:0] w_mag;
  logic [7:0]  w_mag_sat;
  logic        w_edge;

  assign w_luma_sum = 16'd77  * {8'd0, r_s0_rgb[23:16]}
                    + 16'd150 * {8'd0, r_s0_rgb[15:8]}
                    + 16'd29  * {8'd0, r_s0_rgb[7:0]};

  assign w_lb0 = r_lb0[r_s1_col];
  assign w_lb1 = r_lb1[r_s1_col];

  assign w_gx_pos = {3'b0, r_p02} + {2'b0, r_p12, 1'b0} + {3'b0, r_p22};
  assign w_gx_neg = {3'b0, r_p00} + {2'b0, r_p10, 1'b0} + {3'b0, r_p20};
  assign w_gy_pos = {3'b0, r_p20} + {2'b0, r_p21, 1'b0} + {3'b0, r_p22};
  assign w_gy_neg = {3'b0, r_p00} + {2'b0, r_p01, 1'b0} + {3'b0, r_p02};

  assign w_ax      = r_gx[10] ? 11'(-r_gx) : 11'(r_gx);
  assign w_ay      = r_gy[10] ? 11'(-r_gy) : 11'(r_gy);
  assign w_mag     = {1'b0, w_ax} + {1'b0, w_ay};
  assign w_mag_sat = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
  assign w_edge    = r_s3_valid && !r_s3_border && (w_mag_sat > threshold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_s0_valid <= 1'b0; r_s0_border <= 1'b0; r_s0_rgb <= '0; r_s0_col <= '0;
      r_s1_valid <= 1'b0; r_s1_border <= 1'b0; r_s1_y   <= '0; r_s1_col <= '0;
      r_s2_valid <= 1'b0; r_s2_border <= 1'b0;
      r_p00 <= '0; r_p01 <= '0; r_p02 <= '0;
      r_p10 <= '0; r_p11 <= '0; r_p12 <= '0;
      r_p20 <= '0; r_p21 <= '0; r_p22 <= '0;
      r_s3_valid <= 1'b0; r_s3_border <= 1'b0; r_gx <= '0; r_gy <= '0;
      valid_s      <= 1'b0;
      data_s_sobel <= '0;
    end else if (w_en) begin
      r_s0_valid <= valid_m;
      if (valid_m) begin
        r_s0_rgb    <= data_m_rgb;
        r_s0_col    <= r_col;
        r_s0_border <= (r_row < RW'(2)) || (r_col < CW'(2));
        if (r_col == CW'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      r_s1_valid  <= r_s0_valid;
      r_s1_y      <= 8'(w_luma_sum >> 8);
      r_s1_col    <= r_s0_col;
      r_s1_border <= r_s0_border;

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_border <= r_s1_border;
        r_p00 <= r_p01; r_p01 <= r_p02; r_p02 <= w_lb1;
        r_p10 <= r_p11; r_p11 <= r_p12; r_p12 <= w_lb0;
        r_p20 <= r_p21; r_p21 <= r_p22; r_p22 <= r_s1_y;
      end

      r_s3_valid  <= r_s2_valid;
      r_s3_border <= r_s2_border;
      r_gx        <= w_gx_pos - w_gx_neg;
      r_gy        <= w_gy_pos - w_gy_neg;

      valid_s      <= r_s3_valid;
      data_s_sobel <= w_edge ? 24'hFFFFFF : 24'h000000;
    end
  end

  // Line buffers are deliberately unreset; border masking hides stale contents.
  always_ff @(posedge clk) begin
    if (w_en && r_s1_valid) begin
      r_lb1[r_s1_col] <= w_lb0;
      r_lb0[r_s1_col] <= r_s1_y;
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Self-checking bench for sobel_edge_filter on an 8x8 frame: table of frame scenarios
// checked pixel-by-pixel against a plain-arithmetic Sobel model, plus reset/stall sequences.
module tb_sobel_edge_filter;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  threshold;
  logic [23:0] data_m_rgb;
  logic        valid_m;
  logic        ready_s;
  logic        valid_s;
  logic        ready_m;
  logic [23:0] data_s_sobel;

  sobel_edge_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .threshold(threshold),
    .data_m_rgb(data_m_rgb), .valid_m(valid_m), .ready_s(ready_s),
    .valid_s(valid_s), .ready_m(ready_m), .data_s_sobel(data_s_sobel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int pat;        // 0 uniform gray, 1 vertical edge, 2 random
    int thr;        // -1 picks a random threshold
    int bubble;     // percent of idle input cycles
    int stall;      // 0 none, 1 single 5-cycle drop, 2 random backpressure
    int exp_white;  // -1 when only the model is checked
  } vec_t;

  vec_t tbl[8];

  logic [23:0] img   [N];
  logic [23:0] exp_q [N];
  int  stall_mode;
  bit  coll_done;
  int  n_out, whites, first_acc, first_valid;

  function automatic int luma(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic build_expected(input int thr);
    int y[N];
    int gx, gy, mag;
    for (int k = 0; k < N; k++) y[k] = luma(img[k]);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 2 || c < 2) begin
          exp_q[r*W+c] = 24'h000000;
        end else begin
          gx = (y[(r-2)*W+c] + 2*y[(r-1)*W+c] + y[r*W+c])
             - (y[(r-2)*W+c-2] + 2*y[(r-1)*W+c-2] + y[r*W+c-2]);
          gy = (y[r*W+c-2] + 2*y[r*W+c-1] + y[r*W+c])
             - (y[(r-2)*W+c-2] + 2*y[(r-2)*W+c-1] + y[(r-2)*W+c]);
          mag = iabs(gx) + iabs(gy);
          if (mag > 255) mag = 255;
          exp_q[r*W+c] = (mag > thr) ? 24'hFFFFFF : 24'h000000;
        end
      end
    end
  endtask

  task automatic fill_image(input int pat);
    for (int k = 0; k < N; k++) begin
      case (pat)
        0:       img[k] = 24'hAAAAAA;
        1:       img[k] = ((k % W) < 4) ? 24'h000000 : 24'hFFFFFF;
        default: img[k] = 24'($urandom);
      endcase
    end
  endtask

  task automatic drive(input int bubble);
    int idx = 0;
    int guard = 0;
    while (idx < N && guard < 3000) begin
      @(posedge clk); #1;
      valid_m    = ($urandom_range(99) >= 32'(bubble));
      data_m_rgb = img[idx];
      @(negedge clk);
      if (stall_mode == 0) check("ready_s_high", 32'(ready_s), 32'd1);
      if (valid_m && ready_s) begin
        if (first_acc < 0) first_acc = cyc + 1;
        idx++;
      end
      guard++;
    end
    @(posedge clk); #1;
    valid_m = 1'b0;
    if (idx < N) check("drive_timeout", 32'(idx), 32'(N));
  endtask

  task automatic collect();
    int guard = 0;
    while (n_out < N && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (valid_s && first_valid < 0) first_valid = cyc;
      if (valid_s && ready_m) begin
        check($sformatf("pixel[%0d]", n_out), 32'(data_s_sobel), 32'(exp_q[n_out]));
        if (data_s_sobel == 24'hFFFFFF) whites++;
        n_out++;
      end
    end
    if (n_out < N) check("collect_timeout", 32'(n_out), 32'(N));
    @(negedge clk);
    check("no_extra_output", 32'(valid_s), 32'd0);
    coll_done = 1'b1;
  endtask

  task automatic ready_ctl();
    logic        snap_v;
    logic [23:0] snap_d;
    ready_m = 1'b1;
    if (stall_mode == 1) begin
      while (n_out < 10 && !coll_done) @(negedge clk);
      @(posedge clk); #1;
      ready_m = 1'b0;
      snap_v = 1'b0;
      snap_d = '0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) begin
          snap_v = valid_s;
          snap_d = data_s_sobel;
          check("stall_valid_s", 32'(valid_s), 32'd1);
        end else begin
          check("stall_hold_valid", 32'(valid_s), 32'(snap_v));
          check("stall_hold_data", 32'(data_s_sobel), 32'(snap_d));
        end
        check("stall_ready_s_low", 32'(ready_s), 32'd0);
      end
      @(posedge clk); #1;
      ready_m = 1'b1;
    end else if (stall_mode == 2) begin
      while (!coll_done) begin
        @(posedge clk); #1;
        ready_m = ($urandom_range(3) != 0);
      end
    end
    while (!coll_done) @(negedge clk);
    ready_m = 1'b1;
  endtask

  task automatic run_frame(input vec_t v);
    int thr;
    thr = (v.thr < 0) ? int'($urandom_range(255)) : v.thr;
    threshold = 8'(thr);
    fill_image(v.pat);
    build_expected(thr);
    stall_mode  = v.stall;
    coll_done   = 1'b0;
    n_out       = 0;
    whites      = 0;
    first_acc   = -1;
    first_valid = -1;
    fork
      drive(v.bubble);
      collect();
      ready_ctl();
    join
    check("latency", 32'(first_valid - first_acc), 32'd4);
    if (v.exp_white >= 0) check("white_count", 32'(whites), 32'(v.exp_white));
  endtask

  initial begin
    tbl[0] = '{0,  30,  0, 0,  0};
    tbl[1] = '{1,  30,  0, 0, 12};
    tbl[2] = '{1, 255,  0, 0,  0};
    tbl[3] = '{1, 254,  0, 0, 12};
    tbl[4] = '{1,  30,  0, 1, 12};
    tbl[5] = '{1,  30, 40, 0, 12};
    tbl[6] = '{2,  -1, 30, 2, -1};
    tbl[7] = '{2,  -1,  0, 0, -1};

    rst        = 1'b0;
    valid_m    = 1'b0;
    ready_m    = 1'b1;
    threshold  = 8'd0;
    data_m_rgb = '0;
    #1 rst = 1'b1;
    #20;
    @(negedge clk);
    check("rst_valid_s", 32'(valid_s), 32'd0);
    check("rst_data", 32'(data_s_sobel), 32'd0);
    check("rst_ready_s", 32'(ready_s), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_s", 32'(ready_s), 32'd1);

    for (int t = 0; t < 8; t++) run_frame(tbl[t]);

    // Mid-frame reset: stream 30 pixels, reset, then a fresh frame must match the model.
    threshold = 8'd30;
    fill_image(1);
    begin
      int acc = 0;
      int guard = 0;
      while (acc < 30 && guard < 500) begin
        @(posedge clk); #1;
        valid_m    = 1'b1;
        data_m_rgb = img[acc];
        @(negedge clk);
        if (ready_s) acc++;
        guard++;
      end
      check("pre_rst_stream", 32'(acc), 32'd30);
    end
    @(posedge clk); #1;
    check("pre_rst_valid_s", 32'(valid_s), 32'd1);
    rst     = 1'b1;
    valid_m = 1'b0;
    #1;
    check("mid_rst_valid_s", 32'(valid_s), 32'd0);
    check("mid_rst_data", 32'(data_s_sobel), 32'd0);
    check("mid_rst_ready_s", 32'(ready_s), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_rst_ready_s", 32'(ready_s), 32'd1);
    check("mid_post_rst_valid_s", 32'(valid_s), 32'd0);
    run_frame(tbl[1]);
    run_frame(tbl[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
